// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial unsigned adder. A single 1-bit full-adder cell (two half adders
// plus an OR gate) is stepped over a WIDTH-bit operand pair, LSB first, one
// bit per clock. The block owns the operand shift registers, the result shift
// register, the carry flip-flop, the bit counter and the start/busy/done
// handshake.
//
// Parameters:
//   WIDTH  operand/result width in bits, 1..32
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset; aborts any addition in flight
//   start  request to begin an addition, sampled each rising edge
//   a, b   operands, captured only on the edge that accepts start
//   busy   high while bits are being processed (exactly WIDTH cycles)
//   done   one-cycle pulse when sum/cout have just been updated
//   sum    registered result of the last completed addition
//   cout   registered carry-out of the last completed addition
//
// Handshake: start is accepted on any rising edge where the controller is in
// IDLE or DONE and rst is low; that edge captures a/b and raises busy. busy
// stays high for WIDTH cycles, then done pulses for one cycle together with
// the new sum/cout. start seen while busy is ignored (not queued). Holding
// start high gives one addition every WIDTH+1 cycles. busy and done are
// never high together. Every output comes straight from a flip-flop.
// -----------------------------------------------------------------------------

// One-bit half adder; two of these plus an OR make the full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state, observable hierarchically as serial_adder_ctrl.state.
    state_t state;
    state_t state_next;

    // Datapath registers.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry_q;
    logic [CW-1:0]    cnt;

    // Control strobes decoded by the next-state process.
    logic accept;   // capture operands and begin a new run
    logic step;     // process one bit this cycle
    logic last;     // the bit processed this cycle is the MSB

    // Full-adder cell built from two half adders.
    logic ha0_s;
    logic ha0_c;
    logic cell_s;
    logic ha1_c;
    logic cell_c;

    half_adder u_ha0 (
        .a (op_a[0]),
        .b (op_b[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (cell_s),
        .c (ha1_c)
    );

    assign cell_c = ha0_c | ha1_c;

    // Result register shifted right with the new sum bit entering at the MSB.
    // Written as shift-and-or so the expression stays legal for WIDTH=1.
    logic [WIDTH-1:0] res_next;
    assign res_next = (res >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end

            RUN: begin
                // start is deliberately not looked at here.
                step = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // busy/done are registered copies of the state being entered,
            // so they line up exactly with RUN and DONE.
            busy <= (state_next == RUN);
            done <= (state_next == DONE);

            if (accept) begin
                op_a    <= a;
                op_b    <= b;
                res     <= '0;
                carry_q <= 1'b0;
                cnt     <= '0;
            end

            if (step) begin
                op_a    <= op_a >> 1;
                op_b    <= op_b >> 1;
                res     <= res_next;
                carry_q <= cell_c;
                // On the final bit the counter is left at WIDTH-1 rather than
                // wrapping; the next accept reloads it.
                if (!last) begin
                    cnt <= cnt + CW'(1);
                end
            end

            // sum/cout only move on the edge that enters DONE.
            if (last) begin
                sum  <= res_next;
                cout <= cell_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Bench for serial_adder_ctrl. Main instance at WIDTH=8, second instance at
// WIDTH=1. Expected results are {cout,sum} = a + b computed with plain
// arithmetic and pushed on a queue when a request is issued; a monitor on the
// falling edge pops on every done pulse and also checks that sum/cout hold
// between completions and that busy/done never overlap.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    // WIDTH=1 instance
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    logic [W:0] exp_q[$];
    logic [W:0] hold_exp;
    logic       mon_en;
    int         n_vec;
    int         n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: exact unsigned sum, one bit wider than the operands.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // -------------------------------------------------------------------------
    // Monitor (falling edge)
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy && done) begin
                chk("busy_done_overlap", 32'(busy & done), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    hold_exp = exp_q.pop_front();
                    chk("result", 32'({cout, sum}), 32'(hold_exp));
                end
            end else begin
                chk("result_hold", 32'({cout, sum}), 32'(hold_exp));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks (drive and sample 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
        start = 1'b1;
        a     = ia;
        b     = ib;
        exp_q.push_back(ref_add(ia, ib));
    endtask

    // Waits from the accepting edge E0 until done; k = edges after E0,
    // bc = cycles with busy high. poke>0 pulses start (0x11+0x22) so it is
    // sampled at E0+poke+1, inside the run.
    task automatic wait_done(input bit hold, input int poke, output int k, output int bc);
        tick();
        k  = 0;
        bc = 0;
        chk("busy_after_e0", 32'(busy), 32'd1);
        chk("done_after_e0", 32'(done), 32'd0);
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        while (!done && k < 40) begin
            if (busy) bc++;
            tick();
            k++;
            if (k == poke) begin
                start = 1'b1;
                a     = 8'h11;
                b     = 8'h22;
            end else begin
                if (!hold) start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
        end
    endtask

    task automatic run_single(input logic [W-1:0] ia, input logic [W-1:0] ib, input int poke);
        int k;
        int bc;
        issue(ia, ib);
        wait_done(1'b0, poke, k, bc);
        chk("latency", 32'(k), 32'(W));
        chk("busy_cycles", 32'(bc), 32'(W));
        start = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    task automatic run_b2b(input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic [W-1:0] ya, input logic [W-1:0] yb);
        int k;
        int bc;
        issue(xa, xb);
        wait_done(1'b1, 0, k, bc);
        chk("b2b_latency1", 32'(k), 32'(W));
        chk("b2b_busy1", 32'(bc), 32'(W));
        // Now in the DONE cycle with start still high.
        issue(ya, yb);
        wait_done(1'b0, 0, k, bc);
        chk("b2b_latency2", 32'(k), 32'(W));
        chk("b2b_busy2", 32'(bc), 32'(W));
        start = 1'b0;
        tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_abort(input logic [W-1:0] ia, input logic [W-1:0] ib);
        issue(ia, ib);
        tick();                       // E0
        start = 1'b0;
        repeat (3) tick();            // E0+3
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();                       // E0+4 samples rst
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'({cout, sum}), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        hold_exp = '0;
        mon_en   = 1'b1;
        repeat (12) tick();           // any done here is unexpected
        chk("abort_quiet_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_w1(input logic [0:0] ia, input logic [0:0] ib);
        logic [1:0] e;
        e      = {1'b0, ia} + {1'b0, ib};
        start1 = 1'b1;
        a1     = ia;
        b1     = ib;
        tick();                       // E0
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        chk("w1_busy_e0", 32'(busy1), 32'd1);
        chk("w1_done_e0", 32'(done1), 32'd0);
        tick();                       // E0+1
        chk("w1_done_e1", 32'(done1), 32'd1);
        chk("w1_busy_e1", 32'(busy1), 32'd0);
        chk("w1_result", 32'({cout1, sum1}), 32'(e));
        tick();
        chk("w1_done_clear", 32'(done1), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        n_vec    = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        hold_exp = '0;
        rst      = 1'b1;
        start    = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        start1   = 1'b1;
        a1       = 1'b1;
        b1       = 1'b1;

        // Reset held two cycles with start high.
        repeat (2) begin
            tick();
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_result", 32'({cout, sum}), 32'd0);
        end
        rst    = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_result", 32'({cout, sum}), 32'd0);
        mon_en = 1'b1;

        // Directed patterns.
        run_single(8'hFF, 8'h01, 0);
        run_single(8'hA5, 8'h5A, 0);
        run_single(8'h80, 8'h80, 0);
        run_single(8'h00, 8'h00, 0);
        run_single(8'h0F, 8'h01, 2);  // start pulsed mid-run is ignored
        run_b2b(8'h12, 8'h34, 8'h7F, 8'h01);
        run_abort(8'h33, 8'h44);
        run_single(8'hC3, 8'h7E, 0);

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_b2b(ra, rb, W'($urandom), W'($urandom));
            end else begin
                run_single(ra, rb, int'($urandom_range(0, 6)));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Minimum width instance.
        run_w1(1'b1, 1'b1);
        run_w1(1'b0, 1'b1);
        run_w1(1'b1, 1'b0);
        run_w1(1'b0, 1'b0);

        repeat (3) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
